// File: rtl/bus_encoder.sv
// 16-to-4 request encoder with a one-deep valid/ready output register.
// Grant policy is either fixed (highest bit wins) or round-robin from a rotating pointer.
module bus_encoder #(
  parameter int ROUND_ROBIN = 0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [15:0] encIn,
  input  logic        inValid,
  output logic        inReady,
  output logic [3:0]  encOut,
  output logic        outValid,
  input  logic        outReady,
  output logic        multiHot,
  output logic        zeroHot,
  output logic [7:0]  errCount
);

  logic [3:0]  enc_q, enc_d;
  logic        valid_q, valid_d;
  logic        multi_q, multi_d;
  logic        zero_q, zero_d;
  logic [7:0]  err_q, err_d;
  logic [3:0]  ptr_q, ptr_d;

  logic        capture;
  logic        req_multi, req_zero;
  logic [15:0] rot;
  logic [3:0]  fix_idx, rot_idx, grant;

  assign inReady   = (!valid_q || outReady) && !clear;
  assign capture   = inValid && inReady;
  assign req_zero  = ~|encIn;
  assign req_multi = |(encIn & (encIn - 16'd1));

  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < 16; i++)
      if (encIn[i]) fix_idx = 4'(i);
  end

  // Rotate requests so the pointer sits at bit 0; lowest set bit is the next grant.
  always_comb begin
    rot     = '0;
    rot_idx = '0;
    for (int i = 0; i < 16; i++)
      rot[i] = encIn[ptr_q + 4'(i)];
    for (int i = 15; i >= 0; i--)
      if (rot[i]) rot_idx = 4'(i);
  end

  always_comb begin
    grant = '0;
    if (!req_zero)
      grant = (ROUND_ROBIN != 0) ? (ptr_q + rot_idx) : fix_idx;
  end

  always_comb begin
    enc_d   = enc_q;
    valid_d = valid_q;
    multi_d = multi_q;
    zero_d  = zero_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    if (capture) begin
      enc_d   = grant;
      valid_d = 1'b1;
      multi_d = req_multi;
      zero_d  = req_zero;
      if (req_multi && err_q != 8'hFF) err_d = err_q + 8'd1;
      if (ROUND_ROBIN != 0 && !req_zero) ptr_d = grant + 4'd1;
    end else if (valid_q && outReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      enc_q   <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= '0;
      ptr_q   <= '0;
    end else begin
      enc_q   <= enc_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
    end
  end

  assign encOut   = enc_q;
  assign outValid = valid_q;
  assign multiHot = multi_q;
  assign zeroHot  = zero_q;
  assign errCount = err_q;

endmodule

// File: tb/tb_bus_encoder.sv
// Scoreboard bench driving a fixed-priority and a round-robin bus_encoder with shared stimulus.
module tb_bus_encoder;

  typedef struct packed {
    logic [3:0] enc;
    logic       multi;
    logic       zero;
    logic [7:0] err;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [15:0] enc_in = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_f, out_valid_f, multi_f, zero_f;
  logic [3:0]  enc_f;
  logic [7:0]  err_f;
  logic        in_ready_r, out_valid_r, multi_r, zero_r;
  logic [3:0]  enc_r;
  logic [7:0]  err_r;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t qf[$];
  exp_t qr[$];
  bit       m_valid = 1'b0;
  int       m_err   = 0;
  int       m_ptr   = 0;

  always #5 clock = ~clock;

  bus_encoder #(.ROUND_ROBIN(0)) dut_f (
    .clock(clock), .clear(clear), .encIn(enc_in), .inValid(in_valid), .inReady(in_ready_f),
    .encOut(enc_f), .outValid(out_valid_f), .outReady(out_ready),
    .multiHot(multi_f), .zeroHot(zero_f), .errCount(err_f));

  bus_encoder #(.ROUND_ROBIN(1)) dut_r (
    .clock(clock), .clear(clear), .encIn(enc_in), .inValid(in_valid), .inReady(in_ready_r),
    .encOut(enc_r), .outValid(out_valid_r), .outReady(out_ready),
    .multiHot(multi_r), .zeroHot(zero_r), .errCount(err_r));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference grant: highest set bit, or the nearest set bit at or above ptr with wrap.
  function automatic int ref_grant(input logic [15:0] x, input int p, input bit rr);
    int above = -1;
    int lowest = -1;
    if (x == 0) return 0;
    if (!rr) begin
      for (int k = 15; k >= 0; k--) if (x[k]) return k;
    end
    for (int k = 0; k < 16; k++) begin
      if (x[k]) begin
        if (lowest < 0) lowest = k;
        if (k >= p && above < 0) above = k;
      end
    end
    return (above >= 0) ? above : lowest;
  endfunction

  task automatic cyc(input bit clr, input bit vld, input logic [15:0] data, input bit rdy);
    bit cap;
    int cnt, gf, gr;
    exp_t e;
    @(negedge clock);
    #1;
    clear = clr; in_valid = vld; enc_in = data; out_ready = rdy;
    #1;
    chk("inReady_fixed", in_ready_f, (!m_valid || rdy) && !clr);
    chk("inReady_rr", in_ready_r, (!m_valid || rdy) && !clr);
    cap = vld && (!m_valid || rdy) && !clr;
    @(posedge clock);
    if (clr) begin
      qf.delete(); qr.delete();
      m_valid = 1'b0; m_err = 0; m_ptr = 0;
    end else if (cap) begin
      cnt = $countones(data);
      if (cnt > 1 && m_err < 255) m_err++;
      gf = ref_grant(data, 0, 1'b0);
      gr = ref_grant(data, m_ptr, 1'b1);
      e.multi = (cnt > 1); e.zero = (cnt == 0); e.err = 8'(m_err);
      e.enc = 4'(gf); qf.push_back(e);
      e.enc = 4'(gr); qr.push_back(e);
      if (cnt != 0) m_ptr = (gr + 1) % 16;
      m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // Monitor: compares presented output to queue head each cycle; pops when the consumer takes it.
  always @(negedge clock) begin
    #2;
    chk("outValid_fixed", out_valid_f, qf.size() != 0);
    chk("outValid_rr", out_valid_r, qr.size() != 0);
    if (qf.size() != 0) chk("out_fixed{enc,multi,zero,err}", {enc_f, multi_f, zero_f, err_f}, qf[0]);
    if (qr.size() != 0) chk("out_rr{enc,multi,zero,err}", {enc_r, multi_r, zero_r, err_r}, qr[0]);
    if (qf.size() != 0 && out_ready) void'(qf.pop_front());
    if (qr.size() != 0 && out_ready) void'(qr.pop_front());
  end

  function automatic logic [15:0] rand_multi();
    int a = $urandom_range(15);
    int b = (a + 1 + $urandom_range(14)) % 16;
    return 16'($urandom) | (16'd1 << a) | (16'd1 << b);
  endfunction

  initial begin
    logic [15:0] d;
    int sel;
    repeat (3) cyc(1, 1, 16'hFFFF, 1);
    #1;
    chk("reset_state_fixed", {out_valid_f, enc_f, multi_f, zero_f, err_f}, '0);
    chk("reset_state_rr", {out_valid_r, enc_r, multi_r, zero_r, err_r}, '0);

    for (int k = 0; k < 16; k++) cyc(0, 1, 16'd1 << k, 1);
    cyc(0, 1, 16'h8001, 1);
    #1;
    chk("fixed_8001_enc", enc_f, 4'd15);
    chk("fixed_8001_err", err_f, 8'd1);

    cyc(1, 0, 16'h0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 16'h8101, 1);
    #1;
    chk("rr_8101_fourth", enc_r, 4'd0);

    cyc(0, 1, 16'h0010, 1);
    repeat (3) cyc(0, 1, 16'h0400, 0);
    #1;
    chk("bp_hold_enc", enc_f, 4'd4);
    cyc(0, 1, 16'h0400, 1);
    #1;
    chk("bp_next_enc", enc_f, 4'd10);

    cyc(0, 1, 16'h0000, 1);
    #1;
    chk("zero_flags", {zero_f, multi_f, enc_f}, 6'b10_0000);

    for (int i = 0; i < 260; i++) cyc(0, 1, rand_multi(), 1);
    #1;
    chk("err_saturated", err_f, 8'd255);

    cyc(0, 1, 16'h0300, 1);
    cyc(0, 1, 16'h0500, 0);
    cyc(1, 1, 16'h0700, 0);
    #1;
    chk("midop_clear_valid", out_valid_r, 1'b0);
    chk("midop_clear_err", err_r, 8'd0);
    cyc(0, 1, 16'hFFFF, 1);
    #1;
    chk("rr_after_clear_ffff", enc_r, 4'd0);

    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(3);
      case (sel)
        0: d = 16'h0;
        1: d = 16'd1 << $urandom_range(15);
        2: d = rand_multi();
        default: d = 16'($urandom);
      endcase
      cyc($urandom_range(49) == 0, $urandom_range(3) != 0, d, $urandom_range(3) != 0);
    end
    repeat (3) cyc(0, 0, 16'h0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
